glitch_filter: RTL
==================

// Module: glitch_filter
// PURPOSE
//   Multi-channel, parametrised glitch eliminator: per-channel Moore FSM plus counter.
//   A channel's output changes only after its input holds the new level for a set
//   number of consecutive samples.
//   Separate rise and fall thresholds give hysteresis.
//   Sits between synchronised external inputs (switches, sensor lines) and control logic.
// PARAMETERS
//   WIDTH    1  number of independent channels (>=1)
//   ON_CNT   2  consecutive 1-samples needed to assert a channel (1..65535)
//   OFF_CNT  2  consecutive 0-samples needed to deassert a channel (1..65535)
//   CNT_W    localparam = $clog2(max(ON_CNT,OFF_CNT))+1, counter width per channel
// PORTS
//   clk       in   1      single clock; all state updates on posedge
//   rst       in   1      asynchronous, active-high reset
//   sample_en in   1      sample strobe; FSMs/counters advance only when 1 (tie 1 = every clk)
//   in        in   WIDTH  raw levels; synchronous to clk (async sources synchronised upstream)
//   out       out  WIDTH  filtered levels, Moore outputs (function of state only)
// BEHAVIOUR
//   - Reset: all channels -> S_LOW, counters 0, out=0 (immediately on rst rise, async).
//     Pulses (CONFIGURATION) also 0.
//   - States per channel, one-hot: S_LOW(out0) S_RISE(out0) S_HIGH(out1) S_FALL(out1).
//   - Transitions; evaluated only on posedge clk with sample_en=1, else hold state+cnt:
//     S_LOW:  in=1 -> S_RISE, cnt=1. If ON_CNT==1 -> S_HIGH directly. in=0 -> stay.
//     S_RISE: in=0 -> S_LOW, cnt=0.
//             in=1, cnt==ON_CNT-1 -> S_HIGH, cnt=0.
//             in=1, otherwise -> cnt+1.
//     S_HIGH: mirror of S_LOW on in=0 (S_FALL, cnt=1; OFF_CNT==1 -> S_LOW directly).
//     S_FALL: in=1 -> S_HIGH, cnt=0.
//             in=0, cnt==OFF_CNT-1 -> S_LOW, cnt=0.
//             in=0, otherwise -> cnt+1.
//   - Latency: out rises after the ON_CNT-th consecutive qualifying 1-sample edge.
//     Example: ON_CNT=2, sample_en=1, in rises before edge k -> out=1 after edge k+1.
//     Falling edge behaves the same with OFF_CNT.
//   - A glitch shorter than the threshold never reaches out.
//     Each opposite-level sample fully restarts the count (no partial credit).
//   - sample_en=0 cycles are ignored: neither break nor extend a run.
//     Qualifying samples need not be adjacent clocks.
//   - Counter never exceeds max(ON_CNT,OFF_CNT)-1. No wrap-around.
//   - Channels are fully independent. Simultaneous events on different channels need
//     no arbitration.
//   - Reset asserted mid-count: channel aborts, returns to S_LOW/out=0.
//     First sample after rst release starts from S_LOW.
//   - Illegal one-hot encoding (default branch) -> S_LOW, cnt=0 on next sampled edge.
// CONFIGURATION
//   GLITCH_FILTER_EDGE_EN defined: adds two ports.
//     rise_pulse out WIDTH: 1-clk pulse on the clock where out goes 0->1.
//     fall_pulse out WIDTH: 1-clk pulse on the clock where out goes 1->0.
//     Both are registered and go high in the same cycle out changes. Reset value 0.
//   Macro undefined: ports and logic absent; out behaviour identical.
// TESTING
//   1 Reset: rst=1 mid-cycle with in=all 1s -> out=0 immediately.
//     Release with in=0 -> out stays 0.
//   2 WIDTH=4, ON_CNT=3, OFF_CNT=3, sample_en=1: in[0] high 3 clks -> out[0]=1 after 3rd edge.
//     in[0] low 2 clks then high -> out[0] stays 1.
//   3 Glitch: ON_CNT=2, in[1]=1 for exactly 1 clk -> out[1] never asserts.
//     1,0,1,1 pattern -> asserts only after final pair.
//   4 sample_en=1 every 4th clk, ON_CNT=2: in high 8 clks -> out rises after 2nd strobe edge.
//     Intermediate in=0 on non-strobe clks is ignored.
//   5 Hysteresis ON_CNT=1, OFF_CNT=5: out follows the first 1.
//     It needs 5 consecutive 0-samples to drop; 4 zeros + 1 one -> stays 1.
//   6 GLITCH_FILTER_EDGE_EN: every out transition coincides with a 1-clk rise/fall pulse.
//     All channels toggled in the same cycle -> all pulses in the same cycle.

Source files
------------

// File: rtl/glitch_filter.sv
// ============================================================================
// Module      : glitch_filter
// Description : Multi-channel glitch eliminator with hysteresis. Each channel
//               runs its own Moore FSM plus run-length counter; the filtered
//               output changes only after the raw input has held the new
//               level for ON_CNT (rising) or OFF_CNT (falling) consecutive
//               qualifying samples. A sample qualifies only on a clock edge
//               with sample_en=1.
//
// Ports       : clk        in   1      clock, all state updates on posedge
//               rst        in   1      asynchronous active-high reset
//               sample_en  in   1      sample strobe (tie 1 = every clock)
//               in         in   WIDTH  raw levels, synchronous to clk
//               out        out  WIDTH  filtered levels (registered Moore)
//               rise_pulse out  WIDTH  1-clk pulse when out goes 0->1 (*)
//               fall_pulse out  WIDTH  1-clk pulse when out goes 1->0 (*)
//
//               (*) present only when GLITCH_FILTER_EDGE_EN is defined.
//
// Optional    : GLITCH_FILTER_EDGE_EN - adds registered edge pulse outputs.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module glitch_filter #(
  parameter int WIDTH   = 1,
  parameter int ON_CNT  = 2,
  parameter int OFF_CNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
`ifdef GLITCH_FILTER_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`endif
);

  localparam int MAX_CNT = (ON_CNT > OFF_CNT) ? ON_CNT : OFF_CNT;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  // Terminal counts: the run completes on the sample that finds cnt at N-1.
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CNT - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CNT - 1);

  typedef enum logic [3:0] {
    S_LOW  = 4'b0001,
    S_RISE = 4'b0010,
    S_HIGH = 4'b0100,
    S_FALL = 4'b1000
  } state_t;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             out_d, out_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (sample_en) begin
        case (state_q)
          S_LOW: begin
            if (in[g]) begin
              // A threshold of one means the first 1-sample already qualifies.
              if (ON_CNT == 1) begin
                state_d = S_HIGH;
                cnt_d   = '0;
              end else begin
                state_d = S_RISE;
                cnt_d   = CNT_W'(1);
              end
            end
          end
          S_RISE: begin
            if (!in[g]) begin
              state_d = S_LOW;
              cnt_d   = '0;
            end else if (cnt_q == ON_LAST) begin
              state_d = S_HIGH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          S_HIGH: begin
            if (!in[g]) begin
              if (OFF_CNT == 1) begin
                state_d = S_LOW;
                cnt_d   = '0;
              end else begin
                state_d = S_FALL;
                cnt_d   = CNT_W'(1);
              end
            end
          end
          S_FALL: begin
            if (in[g]) begin
              state_d = S_HIGH;
              cnt_d   = '0;
            end else if (cnt_q == OFF_LAST) begin
              state_d = S_LOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            // Corrupted one-hot encoding recovers to a known safe level.
            state_d = S_LOW;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Output is registered from the next state so out_q is always the Moore
    // decode of state_q, with no extra cycle of latency.
    assign out_d = (state_d == S_HIGH) || (state_d == S_FALL);

`ifdef GLITCH_FILTER_EDGE_EN
    logic rise_d, rise_q;
    logic fall_d, fall_q;

    assign rise_d = out_d & ~out_q;
    assign fall_d = ~out_d & out_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_LOW;
        cnt_q   <= '0;
        out_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign rise_pulse[g] = rise_q;
    assign fall_pulse[g] = fall_q;
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_LOW;
        cnt_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
      end
    end
`endif

    assign out[g] = out_q;
  end

endmodule

`default_nettype wire
